// File: rtl/contreg_8251.sv
// Register/state core of an i8251 USART as seen from the CPU bus: mode/sync/command
// write sequencing, status and data-port readback, with debug taps on command and state.
module contreg_8251 (
  input  logic       I_CLK,
  input  logic       I_RST,
  input  logic       I_CONTROL_EN,
  input  logic       I_DATA_EN,
  input  logic       I_WE,
  input  logic       I_RD,
  input  logic [7:0] I_DATA,
  output logic [7:0] O_DATA,
  output logic [7:0] O_DEBUG_CMD,
  output logic [1:0] O_DEBUG_STATE
);

  typedef enum logic [1:0] {
    ST_MODE  = 2'b00,
    ST_SYNC1 = 2'b01,
    ST_SYNC2 = 2'b10,
    ST_CMD   = 2'b11
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] mode_q, mode_d;
  logic [7:0] sync1_q, sync1_d;
  logic [7:0] sync2_q, sync2_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] data_q, data_d;
  logic       rxrdy_q, rxrdy_d;
  logic       wr_c_prev_q, wr_d_prev_q, rd_d_prev_q;

  logic wr_c, wr_d, rd_d;
  logic wr_c_edge, wr_d_edge, rd_d_edge;
  logic [7:0] status;

  // Strobes are levels that may be held for many cycles; only the rising edge acts.
  assign wr_c      = I_CONTROL_EN & I_WE;
  assign wr_d      = I_DATA_EN & I_WE;
  assign rd_d      = I_DATA_EN & I_RD;
  assign wr_c_edge = wr_c & ~wr_c_prev_q;
  assign wr_d_edge = wr_d & ~wr_d_prev_q;
  assign rd_d_edge = rd_d & ~rd_d_prev_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    sync1_d = sync1_q;
    sync2_d = sync2_q;
    cmd_d   = cmd_q;
    if (wr_c_edge) begin
      unique case (state_q)
        ST_MODE: begin
          mode_d  = I_DATA;
          state_d = (I_DATA[1:0] != 2'b00) ? ST_CMD : ST_SYNC1;
        end
        ST_SYNC1: begin
          sync1_d = I_DATA;
          state_d = mode_q[7] ? ST_CMD : ST_SYNC2;
        end
        ST_SYNC2: begin
          sync2_d = I_DATA;
          state_d = ST_CMD;
        end
        ST_CMD: begin
          // Internal reset returns to mode entry and discards the command word.
          if (I_DATA[6]) begin
            cmd_d   = 8'h00;
            state_d = ST_MODE;
          end else begin
            cmd_d = I_DATA;
          end
        end
        default: state_d = ST_MODE;
      endcase
    end
  end

  // Data-port loopback: a write makes RxRDY follow RxE of the command in force.
  always_comb begin
    data_d  = data_q;
    rxrdy_d = rxrdy_q;
    if (rd_d_edge) rxrdy_d = 1'b0;
    if (wr_d_edge) begin
      data_d  = I_DATA;
      rxrdy_d = cmd_q[2];
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST) begin
    if (!I_RST) begin
      state_q     <= ST_MODE;
      mode_q      <= 8'h00;
      sync1_q     <= 8'h00;
      sync2_q     <= 8'h00;
      cmd_q       <= 8'h00;
      data_q      <= 8'h00;
      rxrdy_q     <= 1'b0;
      wr_c_prev_q <= 1'b0;
      wr_d_prev_q <= 1'b0;
      rd_d_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      rxrdy_q     <= rxrdy_d;
      wr_c_prev_q <= wr_c;
      wr_d_prev_q <= wr_d;
      rd_d_prev_q <= rd_d;
    end
  end

  // No receiver/transmitter behind this core: error flags are zero, TxEMPTY is one.
  assign status = {5'b00000, 1'b1, rxrdy_q, cmd_q[0]};

  always_comb begin
    O_DATA = 8'hFF;
    if (I_CONTROL_EN & I_RD)   O_DATA = status;
    else if (I_DATA_EN & I_RD) O_DATA = data_q;
  end

  assign O_DEBUG_CMD   = cmd_q;
  assign O_DEBUG_STATE = state_q;

endmodule

// File: tb/tb_contreg_8251.sv
// Bench for contreg_8251: directed sequences, a vector table and randomized bus traffic
// checked against a transaction-level model of the 8251 write sequence.
module tb_contreg_8251;

  logic       I_CLK = 1'b0;
  logic       I_RST = 1'b0;
  logic       I_CONTROL_EN = 1'b0;
  logic       I_DATA_EN = 1'b0;
  logic       I_WE = 1'b0;
  logic       I_RD = 1'b0;
  logic [7:0] I_DATA = 8'h00;
  logic [7:0] O_DATA;
  logic [7:0] O_DEBUG_CMD;
  logic [1:0] O_DEBUG_STATE;

  int checks = 0;
  int failures = 0;

  contreg_8251 dut (
    .I_CLK(I_CLK), .I_RST(I_RST), .I_CONTROL_EN(I_CONTROL_EN), .I_DATA_EN(I_DATA_EN),
    .I_WE(I_WE), .I_RD(I_RD), .I_DATA(I_DATA), .O_DATA(O_DATA),
    .O_DEBUG_CMD(O_DEBUG_CMD), .O_DEBUG_STATE(O_DEBUG_STATE)
  );

  always #5 I_CLK = ~I_CLK;

  typedef struct {
    logic       ce, de, we, rd;
    logic [7:0] d;
    logic [1:0] st;
    logic [7:0] cmd;
    logic [7:0] od;
  } vec_t;

  vec_t tbl[28];

  // Model: what the CPU has programmed so far, tracked as "awaiting mode",
  // "sync characters still owed" and "in command phase".
  bit         m_await_mode, m_in_cmd;
  int         m_syncs_left;
  logic [7:0] m_mode, m_cmd, m_data;
  bit         m_rxrdy, p_wc, p_wd, p_rd;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ce, de, we, rd, input logic [7:0] d);
    I_CONTROL_EN = ce; I_DATA_EN = de; I_WE = we; I_RD = rd; I_DATA = d;
  endtask

  task automatic clk1();
    @(posedge I_CLK);
    #1;
  endtask

  task automatic model_reset();
    m_await_mode = 1; m_in_cmd = 0; m_syncs_left = 0;
    m_mode = 0; m_cmd = 0; m_data = 0; m_rxrdy = 0;
    p_wc = 0; p_wd = 0; p_rd = 0;
  endtask

  task automatic model_step(input logic ce, de, we, rd, input logic [7:0] d);
    bit wc, wd, rdd;
    logic [7:0] old_cmd;
    wc = ce & we; wd = de & we; rdd = de & rd;
    old_cmd = m_cmd;
    if (wc && !p_wc) begin
      if (m_await_mode) begin
        m_mode = d; m_await_mode = 0;
        if (d[1:0] != 2'b00) m_in_cmd = 1;
        else m_syncs_left = d[7] ? 1 : 2;
      end else if (!m_in_cmd) begin
        m_syncs_left--;
        if (m_syncs_left == 0) m_in_cmd = 1;
      end else if (d[6]) begin
        m_cmd = 0; m_in_cmd = 0; m_await_mode = 1;
      end else begin
        m_cmd = d;
      end
    end
    if (rdd && !p_rd) m_rxrdy = 0;
    if (wd && !p_wd) begin
      m_data = d; m_rxrdy = old_cmd[2];
    end
    p_wc = wc; p_wd = wd; p_rd = rdd;
  endtask

  function automatic logic [1:0] model_state();
    int n;
    if (m_await_mode) return 2'd0;
    if (m_in_cmd) return 2'd3;
    n = m_mode[7] ? 1 : 2;
    return 2'(n - m_syncs_left + 1);
  endfunction

  function automatic logic [7:0] model_odata(input logic ce, de, rd);
    if (ce && rd) return {5'b0, 1'b1, m_rxrdy, m_cmd[0]};
    if (de && rd) return m_data;
    return 8'hFF;
  endfunction

  task automatic vrow(input int i, input logic ce, de, we, rd, input logic [7:0] d,
                      input logic [1:0] st, input logic [7:0] cmd, input logic [7:0] od);
    tbl[i] = '{ce: ce, de: de, we: we, rd: rd, d: d, st: st, cmd: cmd, od: od};
  endtask

  initial begin
    logic ce, de, we, rd;
    logic [7:0] d;

    vrow(0,  0,0,0,0,8'h00, 2'd0,8'h00,8'hFF);
    vrow(1,  1,0,1,0,8'h0E, 2'd3,8'h00,8'hFF);
    vrow(2,  1,0,1,0,8'h0E, 2'd3,8'h00,8'hFF);
    vrow(3,  0,0,0,0,8'h00, 2'd3,8'h00,8'hFF);
    vrow(4,  1,0,1,0,8'h05, 2'd3,8'h05,8'hFF);
    vrow(5,  0,0,0,0,8'h00, 2'd3,8'h05,8'hFF);
    vrow(6,  0,1,1,0,8'hA5, 2'd3,8'h05,8'hFF);
    vrow(7,  0,0,0,0,8'h00, 2'd3,8'h05,8'hFF);
    vrow(8,  1,0,0,1,8'h00, 2'd3,8'h05,8'h07);
    vrow(9,  0,1,0,1,8'h00, 2'd3,8'h05,8'hA5);
    vrow(10, 1,0,0,1,8'h00, 2'd3,8'h05,8'h05);
    vrow(11, 0,0,0,0,8'h00, 2'd3,8'h05,8'hFF);
    vrow(12, 1,0,1,0,8'h40, 2'd0,8'h00,8'hFF);
    vrow(13, 0,0,0,0,8'h00, 2'd0,8'h00,8'hFF);
    vrow(14, 1,0,1,0,8'h80, 2'd1,8'h00,8'hFF);
    vrow(15, 0,0,0,0,8'h00, 2'd1,8'h00,8'hFF);
    vrow(16, 1,0,1,0,8'h16, 2'd3,8'h00,8'hFF);
    vrow(17, 0,0,0,0,8'h00, 2'd3,8'h00,8'hFF);
    vrow(18, 1,0,1,0,8'h40, 2'd0,8'h00,8'hFF);
    vrow(19, 0,0,0,0,8'h00, 2'd0,8'h00,8'hFF);
    vrow(20, 1,0,1,0,8'h00, 2'd1,8'h00,8'hFF);
    vrow(21, 0,0,0,0,8'h00, 2'd1,8'h00,8'hFF);
    vrow(22, 1,0,1,0,8'hAA, 2'd2,8'h00,8'hFF);
    vrow(23, 0,0,0,0,8'h00, 2'd2,8'h00,8'hFF);
    vrow(24, 1,0,1,0,8'h55, 2'd3,8'h00,8'hFF);
    vrow(25, 0,0,0,0,8'h00, 2'd3,8'h00,8'hFF);
    vrow(26, 1,1,0,1,8'h00, 2'd3,8'h00,8'h04);
    vrow(27, 0,0,0,0,8'h00, 2'd3,8'h00,8'hFF);

    // Reset held 10 clocks, then released.
    drive(0,0,0,0,8'h00);
    I_RST = 1'b0;
    repeat (10) clk1();
    chk("rst_state_during", {6'b0, O_DEBUG_STATE}, 8'h00);
    I_RST = 1'b1;
    clk1();
    chk("rst_state", {6'b0, O_DEBUG_STATE}, 8'h00);
    chk("rst_cmd", O_DEBUG_CMD, 8'h00);
    chk("rst_odata", O_DATA, 8'hFF);

    // Mode 0E held 10 clocks: one action only.
    drive(1,0,1,0,8'h0E);
    for (int i = 0; i < 10; i++) begin
      clk1();
      chk("hold_mode_state", {6'b0, O_DEBUG_STATE}, 8'h03);
      chk("hold_mode_cmd", O_DEBUG_CMD, 8'h00);
    end
    drive(0,0,0,0,8'h00); clk1();
    // Internal reset 40 held 10 clocks: a second action would load mode 40 -> SYNC1.
    drive(1,0,1,0,8'h40);
    for (int i = 0; i < 10; i++) begin
      clk1();
      chk("hold_ireset_state", {6'b0, O_DEBUG_STATE}, 8'h00);
      chk("hold_ireset_cmd", O_DEBUG_CMD, 8'h00);
    end
    drive(0,0,0,0,8'h00); clk1();

    for (int i = 0; i < 28; i++) begin
      drive(tbl[i].ce, tbl[i].de, tbl[i].we, tbl[i].rd, tbl[i].d);
      clk1();
      chk($sformatf("tbl%0d_state", i), {6'b0, O_DEBUG_STATE}, {6'b0, tbl[i].st});
      chk($sformatf("tbl%0d_cmd", i), O_DEBUG_CMD, tbl[i].cmd);
      chk($sformatf("tbl%0d_odata", i), O_DATA, tbl[i].od);
    end

    // Walk to SYNC2 with a live command and data, then reset asynchronously.
    drive(1,0,1,0,8'h40); clk1();
    drive(0,0,0,0,8'h00); clk1();
    drive(1,0,1,0,8'h01); clk1();
    drive(0,0,0,0,8'h00); clk1();
    drive(1,0,1,0,8'h03); clk1();
    drive(0,1,1,0,8'h3C); clk1();
    drive(0,0,0,0,8'h00); clk1();
    chk("pre_cmd", O_DEBUG_CMD, 8'h03);
    drive(1,0,1,0,8'h40); clk1();
    drive(0,0,0,0,8'h00); clk1();
    drive(1,0,1,0,8'h00); clk1();
    drive(0,0,0,0,8'h00); clk1();
    drive(1,0,1,0,8'h11); clk1();
    drive(0,0,0,0,8'h00); clk1();
    chk("pre_state10", {6'b0, O_DEBUG_STATE}, 8'h02);
    #2 I_RST = 1'b0;
    #1;
    chk("async_rst_state", {6'b0, O_DEBUG_STATE}, 8'h00);
    chk("async_rst_cmd", O_DEBUG_CMD, 8'h00);
    drive(0,1,0,1,8'h00); #1;
    chk("async_rst_data", O_DATA, 8'h00);
    drive(1,0,0,1,8'h00); #1;
    chk("async_rst_status", O_DATA, 8'h04);
    drive(0,0,0,0,8'h00);
    clk1();
    I_RST = 1'b1;
    clk1();

    // Randomized traffic against the model.
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      ce = ($urandom_range(0, 2) != 0);
      de = ($urandom_range(0, 2) == 0);
      we = $urandom_range(0, 1);
      rd = $urandom_range(0, 1);
      d  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) d[6] = 1'b0;
      drive(ce, de, we, rd, d);
      clk1();
      model_step(ce, de, we, rd, d);
      chk("rand_state", {6'b0, O_DEBUG_STATE}, {6'b0, model_state()});
      chk("rand_cmd", O_DEBUG_CMD, m_cmd);
      chk("rand_odata", O_DATA, model_odata(ce, de, rd));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
